// File: rtl/mdu_issue.sv
// Issue/sequencing stage in front of the RV64M mul/div engine: operand prep, local div corner cases, result hold.
// Optional watchdog in WAIT is enabled by defining MDU_ISSUE_TIMEOUT_EN.
module mdu_issue #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            eng_req_valid,
  input  logic            eng_req_ready,
  output logic [2:0]      eng_op,
  output logic [XLEN-1:0] eng_src1,
  output logic [XLEN-1:0] eng_src2,
  input  logic            eng_resp_valid,
  input  logic [XLEN-1:0] eng_resp_data,
  output logic            eng_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic            timeout_fire;

  // Decode of the incoming op: bit 3 = W variant, bit 2 = divide family,
  // bit 1 = remainder, bit 0 = unsigned (for the divide family).
  logic            in_w, in_zext, in_rsvd, in_div, in_rem, in_signed;
  logic            div_zero, sgn_ovf, bypass, accept;
  logic [XLEN-1:0] src1_pre, src2_pre, bypass_pre, bypass_res, resp_post;

  always_comb begin
    in_w      = in_op[3];
    in_zext   = in_op[3] & in_op[0];
    in_rsvd   = in_op[3] & ~in_op[2] & (in_op[1:0] != 2'b00);
    in_div    = in_op[2];
    in_rem    = in_op[1];
    in_signed = ~in_op[0];
    src1_pre  = in_src1;
    src2_pre  = in_src2;
    if (in_w) begin
      src1_pre = in_zext ? zext32(in_src1) : sext32(in_src1);
      src2_pre = in_zext ? zext32(in_src2) : sext32(in_src2);
    end
    div_zero = in_div & (src2_pre == '0);
    sgn_ovf  = in_div & in_signed &
               (in_w ? ((in_src1[31:0] == 32'h8000_0000) && (in_src2[31:0] == 32'hFFFF_FFFF))
                     : ((in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_src2)));
    bypass   = in_rsvd | div_zero | sgn_ovf;
    // Divide-by-zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend, remainder = 0.
    if (div_zero) bypass_pre = in_rem ? src1_pre : '1;
    else          bypass_pre = in_rem ? '0 : src1_pre;
    if (in_rsvd)   bypass_res = '0;
    else if (in_w) bypass_res = sext32(bypass_pre);
    else           bypass_res = bypass_pre;
    resp_post = op_q[3] ? sext32(eng_resp_data) : eng_resp_data;
    accept    = in_valid & (state_q == IDLE) & ~flush;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = in_op;
          src1_d = src1_pre;
          src2_d = src2_pre;
          if (bypass) begin
            out_data_d = bypass_res;
            state_d    = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: if (eng_req_ready) state_d = WAIT;
      WAIT: begin
        if (eng_resp_valid) begin
          out_data_d = resp_post;
          state_d    = DONE;
        end else if (timeout_fire) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      out_err_d = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

`ifdef MDU_ISSUE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d        = cnt_q;
    timeout_fire = (state_q == WAIT) & ~eng_resp_valid & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign out_err = out_err_q;
`else
  assign timeout_fire = 1'b0;
  assign out_err      = 1'b0;
`endif

  assign in_ready      = (state_q == IDLE);
  assign eng_req_valid = (state_q == ISSUE);
  assign eng_op        = op_q[2:0];
  assign eng_src1      = src1_q;
  assign eng_src2      = src2_q;
  assign eng_flush     = (flush & ((state_q == ISSUE) | (state_q == WAIT))) | timeout_fire;
  assign out_valid     = (state_q == DONE);
  assign out_data      = out_data_q;

endmodule

// File: tb/tb_mdu_issue.sv
// Directed self-checking bench for mdu_issue with a hand-driven engine stub.
module tb_mdu_issue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [63:0] in_src1 = '0, in_src2 = '0;
  logic        eng_req_valid;
  logic        eng_req_ready = 1'b0;
  logic [2:0]  eng_op;
  logic [63:0] eng_src1, eng_src2;
  logic        eng_resp_valid = 1'b0;
  logic [63:0] eng_resp_data = '0;
  logic        eng_flush;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  mdu_issue #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_op(eng_op),
    .eng_src1(eng_src1), .eng_src2(eng_src2),
    .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data), .eng_flush(eng_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (!reset && eng_req_valid && eng_req_ready) req_cnt <= req_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Accept an op that the stage resolves locally, then drain it.
  task automatic bypass_op(input string tag, input logic [3:0] op,
                           input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] exp);
    int r0;
    r0 = req_cnt;
    in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_noreq"}, 64'(eng_req_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_reqcnt"}, 64'(req_cnt - r0), 64'd0);
  endtask

  // Accept an op and hand it to the engine; returns with the stage in WAIT.
  task automatic issue_op(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2);
    in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2;
    tick();
    in_valid = 1'b0;
    eng_req_ready = 1'b1;
    tick();
    eng_req_ready = 1'b0;
  endtask

  initial begin
    logic ok;
    int   r0, n;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(eng_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_eng_flush", 64'(eng_flush), 64'd0);
    reset = 1'b0;
    tick();

    // MUL with a 33-cycle engine latency
    r0 = req_cnt;
    in_valid = 1'b1; in_op = 4'd0; in_src1 = 64'd3; in_src2 = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    in_valid = 1'b0;
    chk("mul_req_valid", 64'(eng_req_valid), 64'd1);
    chk("mul_eng_op", 64'(eng_op), 64'd0);
    chk("mul_eng_src1", eng_src1, 64'd3);
    chk("mul_eng_src2", eng_src2, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul_in_ready", 64'(in_ready), 64'd0);
    eng_req_ready = 1'b1;
    tick();
    eng_req_ready = 1'b0;
    ok = 1'b1;
    repeat (32) begin
      if (eng_req_valid || out_valid) ok = 1'b0;
      tick();
    end
    chk("mul_wait_quiet", 64'(ok), 64'd1);
    eng_resp_valid = 1'b1; eng_resp_data = 64'hFFFF_FFFF_FFFF_FFFA;
    tick();
    eng_resp_valid = 1'b0;
    chk("mul_out_valid", 64'(out_valid), 64'd1);
    chk("mul_out_data", out_data, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_one_req", 64'(req_cnt - r0), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mul_drained", 64'(out_valid), 64'd0);
    chk("mul_in_ready", 64'(in_ready), 64'd1);

    // Locally resolved corner cases
    bypass_op("divu_zero", 4'd5, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    bypass_op("remu_zero", 4'd7, 64'd100, 64'd0, 64'd100);
    bypass_op("divw_ovf", 4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    bypass_op("remw_ovf", 4'd14, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);
    bypass_op("div_ovf", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    bypass_op("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    bypass_op("remuw_zero", 4'd15, 64'h1234_5678_8000_0001, 64'h5555_5555_0000_0000, 64'hFFFF_FFFF_8000_0001);
    bypass_op("divw_zero", 4'd12, 64'd7, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    bypass_op("rsvd_10", 4'd10, 64'd5, 64'd6, 64'd0);

    // DIVUW: zero-extended operands, sign-extended result
    in_valid = 1'b1; in_op = 4'd13; in_src1 = 64'hAAAA_AAAA_FFFF_FFFE; in_src2 = 64'h0000_0001_0000_0001;
    tick();
    in_valid = 1'b0;
    chk("divuw_src1", eng_src1, 64'h0000_0000_FFFF_FFFE);
    chk("divuw_src2", eng_src2, 64'd1);
    chk("divuw_op", 64'(eng_op), 64'd5);
    eng_req_ready = 1'b1;
    tick();
    eng_req_ready = 1'b0;
    eng_resp_valid = 1'b1; eng_resp_data = 64'h0000_0000_FFFF_FFFE;
    tick();
    eng_resp_valid = 1'b0;
    chk("divuw_out_data", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Stray response in IDLE is ignored
    eng_resp_valid = 1'b1; eng_resp_data = 64'h1111;
    tick();
    eng_resp_valid = 1'b0;
    chk("stray_resp", 64'(out_valid), 64'd0);

    // Flush 5 cycles into WAIT, coinciding with the response
    issue_op(4'd1, 64'd9, 64'd9);
    repeat (5) tick();
    flush = 1'b1; eng_resp_valid = 1'b1; eng_resp_data = 64'hDEAD;
    #1;
    chk("flush_eng_flush", 64'(eng_flush), 64'd1);
    tick();
    flush = 1'b0; eng_resp_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    ok = 1'b1;
    repeat (3) begin
      if (out_valid) ok = 1'b0;
      tick();
    end
    chk("flush_no_out", 64'(ok), 64'd1);

    // Flush coinciding with in_valid: op rejected
    in_valid = 1'b1; in_op = 4'd0; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_reject", 64'(eng_req_valid), 64'd0);
    chk("flush_reject_idle", 64'(in_ready), 64'd1);

    // Output backpressure: hold for 10 cycles
    issue_op(4'd8, 64'd1, 64'd2);
    eng_resp_valid = 1'b1; eng_resp_data = 64'h0000_0000_8000_0002;
    tick();
    eng_resp_valid = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      if (!out_valid || out_data !== 64'hFFFF_FFFF_8000_0002) ok = 1'b0;
      tick();
    end
    chk("hold_stable", 64'(ok), 64'd1);
    chk("hold_data", out_data, 64'hFFFF_FFFF_8000_0002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_drained", 64'(out_valid), 64'd0);

`ifdef MDU_ISSUE_TIMEOUT_EN
    // Watchdog: engine never responds
    issue_op(4'd0, 64'd4, 64'd4);
    n = 0;
    while (!eng_flush && n < 40) begin
      tick();
      n++;
    end
    chk("to_flush_cycle", 64'(n), 64'd15);
    tick();
    chk("to_out_valid", 64'(out_valid), 64'd1);
    chk("to_out_err", 64'(out_err), 64'd1);
    chk("to_out_data", out_data, 64'd0);
    chk("to_flush_pulse", 64'(eng_flush), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("to_err_clear", 64'(out_err), 64'd0);
`else
    n = 0;
    chk("no_to_err", 64'(out_err), 64'(n));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- Issue/sequencing stage directly upstream of the mul/div engine in the RV64 EX stage.
- Accepts one RV64M op per handshake and latches its operands.
- Sign- or zero-extends operands for W variants and resolves divide-by-zero and signed overflow locally.
- Otherwise issues a single-cycle request to the engine, waits for its response, sign-extends W results and holds the result for writeback under valid/ready backpressure.

Parameters:
XLEN, 64, datapath width
TIMEOUT_CYCLES, 128, watchdog limit in WAIT (used only with MDU_ISSUE_TIMEOUT_EN)

Ports:
clock  in  1  clock
reset  in  1  sync reset, active-high
flush  in  1  pipeline flush, aborts any op in flight
in_valid  in  1  op valid from EX
in_ready  out  1  high only in IDLE
in_op  in  4  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU,8 MULW,12 DIVW,13 DIVUW,14 REMW,15 REMUW; 9-11 reserved
in_src1  in  XLEN  rs1 (multiplicand/dividend)
in_src2  in  XLEN  rs2 (multiplier/divisor)
eng_req_valid  out  1  request to engine
eng_req_ready  in  1  engine accepts request
eng_op  out  3  base op 0-7 (W ops mapped to MUL/DIV/DIVU/REM/REMU)
eng_src1  out  XLEN  preprocessed src1
eng_src2  out  XLEN  preprocessed src2
eng_resp_valid  in  1  engine result valid (one-cycle pulse)
eng_resp_data  in  XLEN  engine result (lo or hi as selected by eng_op)
eng_flush  out  1  abort to engine
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
out_data  out  XLEN  final result
out_err  out  1  result produced by watchdog timeout

Behaviour:
- Reset: state IDLE, in_ready=1, eng_req_valid=0, out_valid=0, out_data=0, out_err=0, eng_flush=0, all operand/result registers 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on in_valid&in_ready&~flush, latch op and preprocessed operands.
  - Special case or reserved op -> DONE next cycle (accept-to-out_valid latency 1).
  - Otherwise -> ISSUE.
- ISSUE: eng_req_valid=1, operands stable. On eng_req_ready -> WAIT. eng_req_valid deasserts the cycle after acceptance; exactly one accepted request per op.
- WAIT: on eng_resp_valid, capture post-processed eng_resp_data into out_data -> DONE. eng_resp_valid in any state other than WAIT is ignored.
- DONE: out_valid=1, out_data held stable. On out_ready -> IDLE. A new op is not accepted in the same cycle; in_ready rises the next cycle.
- Preprocessing:
  - MULW/DIVW/REMW: both sources = sext(src[31:0]).
  - DIVUW/REMUW: both sources = zext(src[31:0]).
  - 64-bit ops: sources passed unchanged.
- Post-processing: W ops yield sext(result[31:0]); 64-bit ops pass result through.
- Divide-by-zero (divisor, or divisor[31:0] for W, equals 0):
  - DIV/DIVU family: quotient = all ones.
  - REM/REMU family: result = dividend, after W sign-extension.
- Signed overflow, DIV/REM only:
  - 64-bit case: src1=0x8000_0000_0000_0000 and src2=all ones.
  - W case: src1[31:0]=0x8000_0000 and src2[31:0]=0xFFFF_FFFF.
  - Result: quotient = dividend (sext for W), remainder = 0.
- Reserved ops 9-11: result 0, no engine request.
- eng_flush = flush & (state==ISSUE | state==WAIT), combinational.
- Flush in any state -> IDLE next cycle; out_valid drops and results are discarded.
- Flush coinciding with in_valid: op not accepted.
- Flush coinciding with eng_resp_valid: response discarded.
- Reset mid-operation: immediate return to reset values; the engine is reset separately by the same reset.

Optional Feature:
- Macro: MDU_ISSUE_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without eng_resp_valid: assert eng_flush for one cycle and go to DONE with out_data=0 and out_err=1.
  - out_err clears on leaving DONE.
- Without the macro: no counter, out_err tied 0, WAIT lasts indefinitely.

Test Plan:
- MUL src1=3, src2=0xFFFF_FFFF_FFFF_FFFE; engine stub returns 0xFFFF_FFFF_FFFF_FFFA after 33 cycles -> eng_op=0, single-cycle eng_req_valid, out_data=0xFFFF_FFFF_FFFF_FFFA.
- DIVU src1=100, src2=0 -> no eng_req_valid, out_valid exactly 1 cycle after accept, out_data=0xFFFF_FFFF_FFFF_FFFF. REMU same operands -> out_data=100.
- DIVW src1=0x0000_0000_8000_0000, src2=0x0000_0000_FFFF_FFFF -> bypass, out_data=0xFFFF_FFFF_8000_0000. REMW same operands -> 0.
- DIVUW src1=0xAAAA_AAAA_FFFF_FFFE, src2=0x1_0000_0001 -> eng_src1=0x0000_0000_FFFF_FFFE, eng_src2=1, eng_op=5; engine returns 0xFFFF_FFFE -> out_data=0xFFFF_FFFF_FFFF_FFFE.
- Flush 5 cycles into WAIT, then engine pulses eng_resp_valid -> eng_flush=1 that cycle, IDLE next, out_valid never asserts, in_ready=1. Second case: out_ready held low 10 cycles in DONE -> out_valid and out_data stable throughout.
- With MDU_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never responds -> eng_flush pulse after 16 WAIT cycles, then out_valid=1, out_err=1, out_data=0.
